// File: rtl/multi_clk_en_gen.sv
// multi_clk_en_gen: N-channel clock-enable generator with runtime divisors, gating, resync and square-wave outputs
module multi_clk_en_gen #(
  parameter int NUM_CH = 4,
  parameter int DIV_W = 16,
  parameter logic [NUM_CH*DIV_W-1:0] INIT_DIV = {16'd0, 16'd1, 16'd907, 16'd20}
) (
  input  logic                    CLK_40,
  input  logic                    reset,
  input  logic [NUM_CH*DIV_W-1:0] div_in,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic                    resync,
  output logic [NUM_CH-1:0]       clk_en,
  output logic [NUM_CH-1:0]       clk_div,
  output logic [NUM_CH*DIV_W-1:0] div_active
);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] cnt, active, pending, nxt_div;
    logic pv, nxt_pv, wrap, idle, en_q, div_q;
    // idle covers every case where a pending divisor is taken without waiting for a wrap
    always_comb begin
      nxt_div = div_load[g] ? div_in[g*DIV_W +: DIV_W] : pending;
      nxt_pv = div_load[g] | pv;
      wrap = (active != '0) && (cnt == active - DIV_W'(1));
      idle = resync | ~ch_enable[g] | (active == '0);
    end
    always_ff @(posedge CLK_40) begin
      if (reset) begin
        cnt <= '0;
        active <= INIT_DIV[g*DIV_W +: DIV_W];
        pending <= '0;
        pv <= 1'b0;
        en_q <= 1'b0;
        div_q <= 1'b0;
      end else begin
        cnt <= (idle || wrap) ? '0 : cnt + DIV_W'(1);
        en_q <= ~idle & wrap;
        div_q <= resync ? 1'b0 : div_q ^ (~idle & wrap);
        pending <= nxt_div;
        pv <= nxt_pv & ~(idle | wrap);
        if (nxt_pv && (idle || wrap)) active <= nxt_div;
      end
    end
    assign clk_en[g] = en_q;
    assign clk_div[g] = div_q;
    assign div_active[g*DIV_W +: DIV_W] = active;
  end
endmodule
